// File: rtl/spi_ctrl_master.sv
// -----------------------------------------------------------------------------
// spi_ctrl_master
//   SPI mode-0 master for the 16-bit register-access frame used by our SPI
//   peripherals: {rw, addr[6:0], data[7:0]}, MSB first.
//   A frame is IDLE -> SETUP -> SHIFT (16 bits) -> HOLD -> IDLE, each
//   SCLK half-period lasting CLK_DIV system clocks.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   start_i    frame request, only looked at in IDLE
//   rw_i       frame bit 15 (1 = write), latched on accepted start
//   addr_i     frame bits 14:8, latched on accepted start
//   wdata_i    frame bits 7:0, latched on accepted start
//   cipo_i     serial data from peripheral
//   sclk_o     SPI clock, idle low
//   copi_o     serial data to peripheral
//   ncs_o      chip select, active low
//   busy_o     high while a frame is in progress
//   done_o     one-cycle pulse when a frame ends
//   rdata_o    byte returned by the most recent read frame
// -----------------------------------------------------------------------------
module spi_ctrl_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic       cipo_i,
    output logic       sclk_o,
    output logic       copi_o,
    output logic       ncs_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o
);

    // Wide enough to hold CLK_DIV itself, so CLK_DIV-1 never wraps.
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [3:0]       bit_q,   bit_d;
    logic             sclk_q,  sclk_d;
    logic [15:0]      sh_q,    sh_d;
    logic [7:0]       rx_q,    rx_d;
    logic             rw_q,    rw_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             done_q,  done_d;

    logic             div_last;

    assign div_last = (div_q == DIV_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;

        // Every non-idle phase is a run of CLK_DIV cycles.
        if (state_q != S_IDLE) begin
            div_d = div_last ? '0 : DIV_W'(div_q + 1'b1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sh_d    = {rw_i, addr_i, wdata_i};
                    rw_d    = rw_i;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_last) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_last) begin
                    if (!sclk_q) begin
                        // Rising SCLK: sample CIPO. Only the last 8 samples
                        // (the data field) survive in rx_q.
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], cipo_i};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            // Last bit stays on COPI through HOLD.
                            state_d = S_HOLD;
                        end else begin
                            sh_d  = {sh_q[14:0], 1'b0};
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!rw_q) rdata_d = rx_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Chip select, busy and COPI follow the state directly so reset
    // releases the bus without waiting for a clock.
    assign busy_o  = (state_q != S_IDLE);
    assign ncs_o   = ~busy_o;
    assign copi_o  = busy_o & sh_q[15];
    assign sclk_o  = sclk_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_spi_ctrl_master.sv
// Bench for spi_ctrl_master: instance 0 uses CLK_DIV=4, instance 1 CLK_DIV=1.
// A peripheral model serves CIPO from a 16-bit response word and captures COPI
// on each SCLK rising edge; frames are compared against {rw,addr,wdata}.
module tb_spi_ctrl_master;

    logic       clk;
    logic       rst_n;
    logic [1:0] start, rw, cipo, sclk, copi, ncs, busy, done;
    logic [6:0] addr  [2];
    logic [7:0] wdata [2];
    logic [7:0] rdata [2];

    logic [15:0] mf  [2];   // word the peripheral shifts out on CIPO
    logic [15:0] cap [2];   // COPI bits captured at SCLK rising edges
    int          rc  [2];   // SCLK rising edges seen in current frame
    logic [7:0]  rdm [2];   // expected rdata

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_ctrl_master #(.CLK_DIV(4)) u_d4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[0]), .rw_i(rw[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .cipo_i(cipo[0]),
        .sclk_o(sclk[0]), .copi_o(copi[0]), .ncs_o(ncs[0]), .busy_o(busy[0]),
        .done_o(done[0]), .rdata_o(rdata[0])
    );

    spi_ctrl_master #(.CLK_DIV(1)) u_d1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[1]), .rw_i(rw[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .cipo_i(cipo[1]),
        .sclk_o(sclk[1]), .copi_o(copi[1]), .ncs_o(ncs[1]), .busy_o(busy[1]),
        .done_o(done[1]), .rdata_o(rdata[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_per
        assign cipo[g] = (rc[g] < 16) ? mf[g][15 - rc[g]] : 1'b0;

        always @(negedge ncs[g]) begin
            rc[g]  = 0;
            cap[g] = '0;
        end

        always @(posedge sclk[g]) begin
            cap[g] = {cap[g][14:0], copi[g]};
            rc[g]  = rc[g] + 1;
        end

        // Bus rules checked on every cycle.
        logic psclk = 1'b0;
        logic pcopi = 1'b0;
        always @(negedge clk) begin
            checks++;
            if ((!ncs[g] && !busy[g]) || (ncs[g] && sclk[g]) ||
                (psclk && sclk[g] && copi[g] !== pcopi)) begin
                errors++;
                $display("FAIL bus_rule[%0d] t=%0t ncs=%b busy=%b sclk=%b copi=%b prev_copi=%b",
                         g, $time, ncs[g], busy[g], sclk[g], copi[g], pcopi);
            end
            psclk = sclk[g];
            pcopi = copi[g];
        end
    end

    function automatic int dv(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    // One frame on instance u. Start pulses at cycles s1/s2 of the frame (0 =
    // none) arrive while busy and must be ignored; fields are scrambled after
    // acceptance to show they are not re-sampled.
    task automatic run_frame(input int u, input bit r, input logic [6:0] a,
                             input logic [7:0] w, input logic [7:0] resp,
                             input int s1, input int s2, input string nm);
        int d = dv(u);
        int bcnt = 0, dcnt = 0, dk = 0, hr = 0, hbad = 0;
        logic [15:0] exp;
        logic [7:0]  rd_done = 8'h00;
        exp   = {r, a, w};
        mf[u] = {8'($urandom), resp};
        @(negedge clk);
        rw[u] = r; addr[u] = a; wdata[u] = w; start[u] = 1'b1;
        for (int k = 1; k <= 34 * d + 3; k++) begin
            @(negedge clk);
            start[u] = (k == s1 || k == s2);
            if (k == 1 || start[u]) begin
                rw[u] = 1'($urandom); addr[u] = 7'($urandom); wdata[u] = 8'($urandom);
            end
            if (busy[u]) bcnt++;
            if (done[u]) begin dcnt++; dk = k; rd_done = rdata[u]; end
            if (sclk[u]) hr++;
            else if (hr != 0) begin if (hr != d) hbad++; hr = 0; end
        end
        start[u] = 1'b0;
        if (!r) rdm[u] = resp;

        checks++;
        if (bcnt !== 34 * d) begin errors++;
            $display("FAIL %s busy_cycles got %0d exp %0d", nm, bcnt, 34 * d); end
        checks++;
        if (dcnt !== 1 || dk !== 34 * d + 1) begin errors++;
            $display("FAIL %s done_pulse got count %0d at %0d exp 1 at %0d", nm, dcnt, dk, 34 * d + 1); end
        checks++;
        if (rc[u] !== 16) begin errors++;
            $display("FAIL %s sclk_rises got %0d exp 16", nm, rc[u]); end
        checks++;
        if (cap[u] !== exp) begin errors++;
            $display("FAIL %s copi_frame got %h exp %h", nm, cap[u], exp); end
        checks++;
        if (hbad !== 0) begin errors++;
            $display("FAIL %s sclk_high_width bad runs %0d exp 0", nm, hbad); end
        checks++;
        if (rd_done !== rdm[u] || rdata[u] !== rdm[u]) begin errors++;
            $display("FAIL %s rdata got %h/%h exp %h", nm, rd_done, rdata[u], rdm[u]); end
    endtask

    task automatic chk_idle(input string nm);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({ncs[u], sclk[u], copi[u], busy[u], done[u], rdata[u]} !== {5'b10000, rdm[u]}) begin
                errors++;
                $display("FAIL %s[%0d] got ncs=%b sclk=%b copi=%b busy=%b done=%b rdata=%h exp 1,0,0,0,0,%h",
                         nm, u, ncs[u], sclk[u], copi[u], busy[u], done[u], rdata[u], rdm[u]);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        rdm[0] = 8'h00; rdm[1] = 8'h00;
        #1 chk_idle("reset_async");
        repeat (3) @(negedge clk);
        chk_idle("reset_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("after_reset");
    endtask

    task automatic test_write;
        run_frame(0, 1'b1, 7'h00, 8'hF0, 8'h3C, 0, 0, "write_f0");
    endtask

    task automatic test_read;
        run_frame(0, 1'b0, 7'h04, 8'($urandom), 8'hA5, 0, 0, "read_a5");
        run_frame(0, 1'b1, 7'($urandom), 8'($urandom), 8'h00, 0, 0, "write_keeps_rdata");
    endtask

    task automatic test_busy_ignore;
        run_frame(0, 1'b0, 7'h2A, 8'h81, 8'h5E, 10, 80, "start_while_busy");
        repeat (20) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || rc[0] !== 16) begin errors++;
            $display("FAIL no_queued_frame got busy=%b rises=%0d exp 0,16", busy[0], rc[0]); end
    endtask

    task automatic test_back_to_back;
        int falls = 0, gap = 0, dn = 0;
        logic pn = 1'b1;
        mf[0] = 16'h0;
        @(negedge clk);
        rw[0] = 1'b1; addr[0] = 7'h55; wdata[0] = 8'hC3; start[0] = 1'b1;
        for (int k = 0; k < 3 * 34 * 4 && dn < 2; k++) begin
            @(negedge clk);
            if (pn && !ncs[0]) falls++;
            if (falls == 2) start[0] = 1'b0;
            if (falls == 1 && ncs[0]) gap++;
            if (done[0]) dn++;
            pn = ncs[0];
        end
        start[0] = 1'b0;
        checks++;
        if (falls !== 2 || dn !== 2) begin errors++;
            $display("FAIL b2b_frames got starts %0d dones %0d exp 2,2", falls, dn); end
        checks++;
        if (gap !== 1) begin errors++;
            $display("FAIL b2b_ncs_gap got %0d exp 1", gap); end
        checks++;
        if (cap[0] !== 16'hD5C3) begin errors++;
            $display("FAIL b2b_second_frame got %h exp d5c3", cap[0]); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_clkdiv1;
        run_frame(1, 1'b1, 7'h11, 8'h55, 8'h00, 0, 0, "div1_w55");
        run_frame(1, 1'b0, 7'h7F, 8'hAA, 8'h96, 0, 0, "div1_read");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            int u = (i < 4) ? 0 : 1;
            run_frame(u, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
                      (i % 3 == 0) ? int'($urandom_range(2, 30)) : 0, 0, "random");
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        bit seen_done = 1'b0;
        mf[0] = 16'hFFFF;
        @(negedge clk);
        rw[0] = 1'b1; addr[0] = 7'h7F; wdata[0] = 8'hFF; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        while (rc[0] < 7 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (rc[0] !== 7) begin errors++;
            $display("FAIL reset_mid_reach got rises %0d exp 7", rc[0]); end
        #2 rst_n = 1'b0;
        rdm[0] = 8'h00; rdm[1] = 8'h00;
        #1 chk_idle("reset_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40 * 4; k++) begin
            @(negedge clk);
            if (done[0] || done[1] || busy[0]) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin errors++;
            $display("FAIL reset_mid_no_done got activity 1 exp 0"); end
        run_frame(0, 1'b0, 7'h33, 8'h0F, 8'h6B, 0, 0, "after_reset_mid");
    endtask

    initial begin
        start = '0; rw = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        mf[0] = '0; mf[1] = '0; rc[0] = 16; rc[1] = 16;
        cap[0] = '0; cap[1] = '0;
        test_reset();
        test_write();
        test_read();
        test_busy_ignore();
        test_back_to_back();
        test_clkdiv1();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
